// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller.
// Loads are staged and swapped into the display register only at a frame boundary while scanning.
module ssd_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                lz_en,
  input  logic [4*DIGITS-1:0] value,
  input  logic                load,
  output logic                load_ack,
  output logic [3:0]          nibble,
  output logic [DIGITS-1:0]   anode,
  output logic                frame
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } state_t;

  state_t              state;
  logic [PW-1:0]       presc_q;
  logic [IW-1:0]       idx_q;
  logic [4*DIGITS-1:0] disp_q;
  logic [4*DIGITS-1:0] stage_q;
  logic                pending_q;

  logic                scanning;
  logic                tick;
  logic                last_digit;
  logic                frame_end;
  logic                xfer;
  logic [IW+1:0]       bit_pos;
  logic [3:0]          cur_nib;
  logic                upper_zero;
  logic                blank_digit;

  always_comb begin
    scanning    = (state == SCAN) && en;
    tick        = scanning && (presc_q == PW'(PRESCALE - 1));
    last_digit  = (idx_q == IW'(DIGITS - 1));
    frame_end   = tick && last_digit;
    // While blank nothing is visible, so a staged value may move over at once.
    xfer        = pending_q && ((state == BLANK) || frame_end);
    bit_pos     = {idx_q, 2'b00};
    cur_nib     = disp_q[bit_pos +: 4];
    upper_zero  = ((disp_q >> bit_pos) == '0);
    blank_digit = lz_en && (idx_q != '0) && upper_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BLANK;
      presc_q   <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      stage_q   <= '0;
      pending_q <= 1'b0;
      anode     <= '1;
      nibble    <= '0;
      load_ack  <= 1'b0;
      frame     <= 1'b0;
    end else begin
      state <= en ? SCAN : BLANK;

      if (scanning) begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          idx_q <= last_digit ? '0 : idx_q + IW'(1);
        end
      end else begin
        presc_q <= '0;
        idx_q   <= '0;
      end

      frame    <= frame_end;
      load_ack <= xfer;

      if (xfer) begin
        disp_q <= stage_q;
      end

      // A load landing on the transfer cycle stays pending for the next frame.
      if (load) begin
        stage_q   <= value;
        pending_q <= 1'b1;
      end else if (xfer) begin
        pending_q <= 1'b0;
      end

      if (scanning && !blank_digit) begin
        anode  <= ~(DIGITS'(1) << idx_q);
        nibble <= cur_nib;
      end else begin
        anode  <= '1;
        nibble <= scanning ? cur_nib : 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: directed scan checks plus a load scoreboard that
// compares each acknowledged value against the next full frame seen on anode/nibble.
module tb_ssd_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int W        = 4 * DIGITS;
  localparam int FRAME    = DIGITS * PRESCALE;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              lz_en;
  logic [W-1:0]      value;
  logic              load;
  logic              load_ack;
  logic [3:0]        nibble;
  logic [DIGITS-1:0] anode;
  logic              frame;

  ssd_scan_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .lz_en    (lz_en),
    .value    (value),
    .load     (load),
    .load_ack (load_ack),
    .nibble   (nibble),
    .anode    (anode),
    .frame    (frame)
  );

  // clock / reset
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // monitor / scoreboard, sampled on the falling edge
  logic [W-1:0]      cap = '0;
  logic [DIGITS-1:0] lit = '0;
  logic [W-1:0]      last_val = '0;
  logic [DIGITS-1:0] last_lit = '0;
  logic [W-1:0]      ack_exp = '0;
  bit                want_chk = 1'b0;
  int                frame_cnt = 0;
  int                ack_cnt = 0;
  int                cyc = 0;
  int                prev_frame_cyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      cap = '0;
      lit = '0;
      want_chk = 1'b0;
      prev_frame_cyc = -1;
    end else begin
      if (!en) prev_frame_cyc = -1;
      if (anode != '1) begin
        chk("anode_onehot", $countones(~anode), 1);
        for (int i = 0; i < DIGITS; i++) begin
          if (!anode[i]) begin
            cap[4*i +: 4] = nibble;
            lit[i] = 1'b1;
          end
        end
      end
      if (frame) begin
        frame_cnt++;
        if (prev_frame_cyc >= 0) chk("frame_period", cyc - prev_frame_cyc, FRAME);
        prev_frame_cyc = cyc;
        last_val = cap;
        last_lit = lit;
        if (want_chk) begin
          chk("disp_after_ack", cap, ack_exp);
          want_chk = 1'b0;
        end
        cap = '0;
        lit = '0;
      end
      if (load_ack) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          ack_exp = exp_q.pop_front();
          want_chk = 1'b1;
        end
        cap = '0;
        lit = '0;
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frames(input int n);
    int start = frame_cnt;
    int t = 0;
    while (frame_cnt < start + n && t < n * FRAME * 3 + 50) begin
      step(1);
      t++;
    end
    if (frame_cnt < start + n) chk("frame_timeout", frame_cnt - start, n);
  endtask

  task automatic wait_ack();
    int start = ack_cnt;
    int t = 0;
    while (ack_cnt == start && t < FRAME * 3 + 50) begin
      step(1);
      t++;
    end
    if (ack_cnt == start) chk("ack_timeout", 0, 1);
  endtask

  // Loads merge while one is still pending: last write wins.
  task automatic do_load(input logic [W-1:0] v);
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = v;
    else exp_q.push_back(v);
    value = v;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  logic [DIGITS-1:0] ea;
  int a0;
  int sync_t;
  logic [W-1:0] rv;

  initial begin
    rst = 1'b1; en = 1'b0; lz_en = 1'b0; load = 1'b0; value = '0;
    step(2);
    chk("rst_anode", anode, 4'hF);
    chk("rst_nibble", nibble, 0);
    chk("rst_frame", frame, 0);
    chk("rst_ack", load_ack, 0);

    // free-running scan of an all-zero display
    rst = 1'b0;
    en = 1'b1;
    sync_t = 0;
    while (anode == 4'hF && sync_t < 10) begin
      step(1);
      sync_t++;
    end
    for (int s = 0; s < DIGITS; s++) begin
      for (int c = 0; c < PRESCALE; c++) begin
        ea = ~(4'b0001 << s);
        chk("scan_anode", anode, ea);
        chk("scan_nibble", nibble, 0);
        step(1);
      end
    end
    wait_frames(2);

    // load while blank: acknowledged the cycle after it is taken
    en = 1'b0;
    step(2);
    do_load(16'h12AF);
    chk("ack_early", load_ack, 0);
    step(1);
    chk("ack_blank", load_ack, 1);
    en = 1'b1;
    wait_frames(2);
    chk("val_12af", last_val, 16'h12AF);
    chk("lit_12af", last_lit, 4'hF);

    // mid-frame load must not tear the frame in progress
    do_load(16'h1234);
    wait_ack();
    wait_frames(1);
    step(5);
    do_load(16'hBEEF);
    wait_ack();
    chk("no_tear", last_val, 16'h1234);
    wait_frames(1);
    chk("val_beef", last_val, 16'hBEEF);

    // leading-zero blanking
    lz_en = 1'b1;
    do_load(16'h0005);
    wait_ack();
    wait_frames(1);
    chk("lz5_lit", last_lit, 4'b0001);
    chk("lz5_val", last_val, 16'h0005);
    do_load(16'h00A0);
    wait_ack();
    wait_frames(1);
    chk("lza0_lit", last_lit, 4'b0011);
    do_load(16'h0000);
    wait_ack();
    wait_frames(1);
    chk("lz0_lit", last_lit, 4'b0001);
    chk("lz0_val", last_val, 16'h0000);
    lz_en = 1'b0;
    wait_frames(2);
    chk("nolz0_lit", last_lit, 4'hF);

    // two loads inside one frame merge into a single acknowledge
    wait_frames(1);
    step(1);
    a0 = ack_cnt;
    do_load(16'h1111);
    step(2);
    do_load(16'h2222);
    wait_ack();
    wait_frames(2);
    chk("merge_acks", ack_cnt - a0, 1);
    chk("merge_val", last_val, 16'h2222);

    // random values
    for (int k = 0; k < 4; k++) begin
      rv = W'($urandom_range(0, 65535));
      do_load(rv);
      wait_ack();
      wait_frames(1);
    end

    // en dropped mid-frame blanks at once and keeps the display contents
    do_load(16'h4C7D);
    wait_ack();
    wait_frames(1);
    step(6);
    en = 1'b0;
    step(1);
    chk("abort_anode", anode, 4'hF);
    step(3);
    chk("abort_nibble", nibble, 0);
    en = 1'b1;
    wait_frames(1);
    chk("abort_keep", last_val, 16'h4C7D);

    // reset with a load still pending
    wait_frames(1);
    step(3);
    a0 = ack_cnt;
    do_load(16'h3333);
    step(1);
    rst = 1'b1;
    step(1);
    exp_q.delete();
    chk("rst_mid_anode", anode, 4'hF);
    chk("rst_mid_ack", load_ack, 0);
    rst = 1'b0;
    wait_frames(2);
    chk("rst_no_ack", ack_cnt - a0, 0);
    chk("rst_disp", last_val, 16'h0000);
    chk("rst_lit", last_lit, 4'hF);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", err_cnt + 1, chk_cnt + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line:
  - DIGITS, default 4, number of multiplexed digits (2..8).
  - PRESCALE, default 50000, clk cycles per digit slot (>=2).
REQ-002 The block SHALL have these ports, one per line:
  - clk  input  1  single system clock, all logic on rising edge.
  - rst  input  1  synchronous, active-high reset.
  - en  input  1  1 = scan, 0 = blank all digits.
  - lz_en  input  1  1 = blank leading zeros.
  - value  input  4*DIGITS  hex value, digit 0 = bits [3:0].
  - load  input  1  one-cycle request to display value.
  - load_ack  output  1  one-cycle pulse, staged value now displayed.
  - nibble  output  4  hex digit for the shared seven-segment decoder.
  - anode  output  DIGITS  digit select, active-low, at most one bit 0.
  - frame  output  1  one-cycle pulse at end of a full scan.
REQ-003 All outputs SHALL be registered; no combinational path from inputs to outputs.

Function
REQ-004 States SHALL be BLANK and SCAN; BLANK->SCAN when en=1, SCAN->BLANK when en=0, both evaluated every cycle.
REQ-005 The prescaler SHALL count 0..PRESCALE-1 in SCAN, wrap to 0, and assert internal tick when it equals PRESCALE-1; it SHALL be held at 0 in BLANK.
REQ-006 The digit index SHALL advance by 1 on tick, wrap from DIGITS-1 to 0, and be held at 0 in BLANK.
REQ-007 frame SHALL pulse for the one cycle after a tick at index DIGITS-1.
REQ-008 In SCAN, anode SHALL have bit [index] = 0 and all other bits 1, updated the cycle after index changes; in BLANK, anode SHALL be all 1s.
REQ-009 nibble SHALL equal disp[4*index+3:4*index], registered with the same timing as anode; it is 0 in BLANK.
REQ-010 With lz_en=1, digit i > 0 SHALL be blanked (anode all 1s for that slot) when disp nibbles i..DIGITS-1 are all zero; digit 0 is never blanked, so value 0 shows one "0".
REQ-011 On load=1, value SHALL be captured into a staging register and a pending flag set; a load while pending SHALL overwrite staging (last write wins); only one load_ack is issued for the merged loads.
REQ-012 In SCAN, the staged value SHALL transfer to the display register on the frame-end tick (no mid-frame tearing); in BLANK, it transfers the cycle after load.
REQ-013 load_ack SHALL pulse one cycle, in the cycle the display register updates; pending then clears.
REQ-014 If load coincides with the transfer cycle, the new value SHALL stay staged with pending kept set and transfer at the next frame end; the prior staged value transfers now.
REQ-015 en dropping mid-frame SHALL abort the scan immediately (index/prescaler to 0 next cycle); disp and staging are kept.

Reset
REQ-016 With rst=1 at a clk edge: state=BLANK, prescaler=0, index=0, disp=0, staging=0, pending=0, anode=all 1s, nibble=0, load_ack=0, frame=0.
REQ-017 rst SHALL override load and en in the same cycle; a pending load is discarded.

Verification (DIGITS=4, PRESCALE=4)
REQ-018 rst, en=1, no load -> anode cycles 1110,1101,1011,0111 every 4 clks, nibble=0, frame pulse every 16 clks.
REQ-019 en=0, load value=16'h12AF -> load_ack next cycle; en=1 -> nibble sequence F,A,2,1 with anode 1110..0111.
REQ-020 SCAN with 16'h1234 shown, load 16'hBEEF mid-frame -> display unchanged until frame end; load_ack and first B/E/E/F frame follow.
REQ-021 lz_en=1, disp=16'h0005 -> slots 1-3 anode 1111, slot 0 anode 1110 nibble 5; disp=16'h0000 -> only digit 0 lit, nibble 0.
REQ-022 Two loads (16'h1111 then 16'h2222) within a frame -> exactly one load_ack, 2222 displayed.
REQ-023 rst asserted mid-frame with pending load -> anode 1111 next cycle, no load_ack, disp=0.
